// File: rtl/tl_tag_mgr.sv
// Non-posted tag manager: hands out the lowest free tag, keeps per-tag request
// context, answers completion-engine lookups over a valid/ready handshake,
// tracks remaining DW across split completions and retires stale tags on timeout.
module tl_tag_mgr #(
  parameter int TAG_W    = 8,
  parameter int NUM_TAGS = 256,
  parameter int LEN_W    = 10,
  parameter int TMO_W    = 16,
  parameter int TMO_CYC  = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid_i,
  output logic             alloc_ready_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic [15:0]      alloc_req_id_i,
  input  logic [31:0]      alloc_addr_i,
  input  logic [LEN_W-1:0] alloc_len_i,
  input  logic [2:0]       alloc_attr_i,
  input  logic             lk_valid_i,
  output logic             lk_ready_o,
  input  logic [TAG_W-1:0] lk_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_hit_o,
  output logic [15:0]      rsp_req_id_o,
  output logic [31:0]      rsp_addr_o,
  output logic [LEN_W:0]   rsp_rem_dw_o,
  output logic [2:0]       rsp_attr_o,
  input  logic             cpl_valid_i,
  input  logic [TAG_W-1:0] cpl_tag_i,
  input  logic [LEN_W:0]   cpl_dw_i,
  output logic             tmo_valid_o,
  output logic [TAG_W-1:0] tmo_tag_o,
  output logic             err_ovr_o,
  output logic [TAG_W:0]   outstanding_o
);

  localparam logic [TAG_W:0]   NUM_TAGS_C = (TAG_W+1)'(NUM_TAGS);
  localparam logic [TAG_W-1:0] LAST_TAG   = TAG_W'(NUM_TAGS - 1);
  localparam logic [TMO_W-1:0] TMO_C      = TMO_W'(TMO_CYC);

  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [15:0]         req_id_q [NUM_TAGS];
  logic [31:0]         addr_q   [NUM_TAGS];
  logic [LEN_W:0]      rem_q    [NUM_TAGS];
  logic [2:0]          attr_q   [NUM_TAGS];
  logic [TMO_W-1:0]    ts_q     [NUM_TAGS];

  logic [TMO_W-1:0] now_q;
  logic [TAG_W-1:0] scan_q;
  logic [TAG_W:0]   out_q, out_d;

  logic             rsp_valid_q, rsp_hit_q;
  logic [15:0]      rsp_req_id_q;
  logic [31:0]      rsp_addr_q;
  logic [LEN_W:0]   rsp_rem_q;
  logic [2:0]       rsp_attr_q;
  logic             tmo_valid_q, err_ovr_q;
  logic [TAG_W-1:0] tmo_tag_q;

  logic [TAG_W-1:0] alloc_tag;
  logic             alloc_fire, lk_fire, lk_hit;
  logic             cpl_busy, cpl_free, cpl_part, cpl_err;
  logic [LEN_W:0]   cpl_rem, alloc_rem;
  logic [TMO_W-1:0] scan_age;
  logic             tmo_hit;

  // Lowest-index free tag from the registered bitmap
  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_tag = TAG_W'(i);
    end
  end

  assign alloc_ready_o = (out_q < NUM_TAGS_C);
  assign alloc_tag_o   = alloc_tag;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign alloc_rem     = (alloc_len_i == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, alloc_len_i};

  assign lk_ready_o = !rsp_valid_q || rsp_ready_i;
  assign lk_fire    = lk_valid_i && lk_ready_o;
  assign lk_hit     = ((TAG_W+1)'(lk_tag_i) < NUM_TAGS_C) && busy_q[lk_tag_i];

  // Tags beyond NUM_TAGS are treated as never busy
  assign cpl_busy = ((TAG_W+1)'(cpl_tag_i) < NUM_TAGS_C) && busy_q[cpl_tag_i];
  assign cpl_rem  = rem_q[cpl_tag_i];
  assign cpl_free = cpl_valid_i && cpl_busy && (cpl_dw_i >= cpl_rem);
  assign cpl_part = cpl_valid_i && cpl_busy && (cpl_dw_i < cpl_rem);
  assign cpl_err  = cpl_valid_i && (!cpl_busy || (cpl_dw_i > cpl_rem));

  // A completion aimed at the scanned tag suppresses its timeout this cycle
  assign scan_age = now_q - ts_q[scan_q];
  assign tmo_hit  = busy_q[scan_q] && (scan_age >= TMO_C) &&
                    !(cpl_valid_i && (cpl_tag_i == scan_q));

  // Next busy bitmap and outstanding count; alloc, cpl-free and timeout hit distinct tags
  always_comb begin
    busy_d = busy_q;
    if (cpl_free)   busy_d[cpl_tag_i] = 1'b0;
    if (tmo_hit)    busy_d[scan_q]    = 1'b0;
    if (alloc_fire) busy_d[alloc_tag] = 1'b1;
    out_d = out_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(cpl_free) - (TAG_W+1)'(tmo_hit);
  end

  // Control state: bitmap, counters, scan pointer, response and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      out_q        <= '0;
      now_q        <= '0;
      scan_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_req_id_q <= '0;
      rsp_addr_q   <= '0;
      rsp_rem_q    <= '0;
      rsp_attr_q   <= '0;
      tmo_valid_q  <= 1'b0;
      tmo_tag_q    <= '0;
      err_ovr_q    <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_q       <= out_d;
      now_q       <= now_q + TMO_W'(1);
      scan_q      <= (scan_q == LAST_TAG) ? '0 : scan_q + TAG_W'(1);
      tmo_valid_q <= tmo_hit;
      tmo_tag_q   <= scan_q;
      err_ovr_q   <= cpl_err;
      if (lk_fire) begin
        rsp_valid_q  <= 1'b1;
        rsp_hit_q    <= lk_hit;
        rsp_req_id_q <= lk_hit ? req_id_q[lk_tag_i] : '0;
        rsp_addr_q   <= lk_hit ? addr_q[lk_tag_i]   : '0;
        rsp_rem_q    <= lk_hit ? rem_q[lk_tag_i]    : '0;
        rsp_attr_q   <= lk_hit ? attr_q[lk_tag_i]   : '0;
      end else if (rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Per-tag context; only meaningful while the busy bit is set, so no reset
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      req_id_q[alloc_tag] <= alloc_req_id_i;
      addr_q[alloc_tag]   <= alloc_addr_i;
      rem_q[alloc_tag]    <= alloc_rem;
      attr_q[alloc_tag]   <= alloc_attr_i;
      ts_q[alloc_tag]     <= now_q;
    end
    if (cpl_part) begin
      rem_q[cpl_tag_i]  <= cpl_rem - cpl_dw_i;
      addr_q[cpl_tag_i] <= addr_q[cpl_tag_i] + 32'({cpl_dw_i, 2'b00});
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_hit_o     = rsp_hit_q;
  assign rsp_req_id_o  = rsp_req_id_q;
  assign rsp_addr_o    = rsp_addr_q;
  assign rsp_rem_dw_o  = rsp_rem_q;
  assign rsp_attr_o    = rsp_attr_q;
  assign tmo_valid_o   = tmo_valid_q;
  assign tmo_tag_o     = tmo_tag_q;
  assign err_ovr_o     = err_ovr_q;
  assign outstanding_o = out_q;

endmodule

// File: tb/tb_tl_tag_mgr.sv
// Directed bench for tl_tag_mgr with a small, non-power-of-two tag pool and short timeout.
module tb_tl_tag_mgr;
  localparam int TAG_W    = 6;
  localparam int NUM_TAGS = 40;
  localparam int LEN_W    = 10;
  localparam int TMO_W    = 16;
  localparam int TMO_CYC  = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             alloc_valid_i, alloc_ready_o;
  logic [TAG_W-1:0] alloc_tag_o;
  logic [15:0]      alloc_req_id_i;
  logic [31:0]      alloc_addr_i;
  logic [LEN_W-1:0] alloc_len_i;
  logic [2:0]       alloc_attr_i;
  logic             lk_valid_i, lk_ready_o;
  logic [TAG_W-1:0] lk_tag_i;
  logic             rsp_valid_o, rsp_ready_i, rsp_hit_o;
  logic [15:0]      rsp_req_id_o;
  logic [31:0]      rsp_addr_o;
  logic [LEN_W:0]   rsp_rem_dw_o;
  logic [2:0]       rsp_attr_o;
  logic             cpl_valid_i;
  logic [TAG_W-1:0] cpl_tag_i;
  logic [LEN_W:0]   cpl_dw_i;
  logic             tmo_valid_o;
  logic [TAG_W-1:0] tmo_tag_o;
  logic             err_ovr_o;
  logic [TAG_W:0]   outstanding_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tl_tag_mgr #(.TAG_W(TAG_W), .NUM_TAGS(NUM_TAGS), .LEN_W(LEN_W), .TMO_W(TMO_W), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_tag_o(alloc_tag_o),
    .alloc_req_id_i(alloc_req_id_i), .alloc_addr_i(alloc_addr_i), .alloc_len_i(alloc_len_i),
    .alloc_attr_i(alloc_attr_i),
    .lk_valid_i(lk_valid_i), .lk_ready_o(lk_ready_o), .lk_tag_i(lk_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_hit_o(rsp_hit_o),
    .rsp_req_id_o(rsp_req_id_o), .rsp_addr_o(rsp_addr_o), .rsp_rem_dw_o(rsp_rem_dw_o),
    .rsp_attr_o(rsp_attr_o),
    .cpl_valid_i(cpl_valid_i), .cpl_tag_i(cpl_tag_i), .cpl_dw_i(cpl_dw_i),
    .tmo_valid_o(tmo_valid_o), .tmo_tag_o(tmo_tag_o), .err_ovr_o(err_ovr_o),
    .outstanding_o(outstanding_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One alloc fire; context fields derived from the expected tag
  task automatic alloc(input logic [31:0] addr, input logic [LEN_W-1:0] len, input logic [TAG_W-1:0] exp_tag);
    alloc_valid_i  = 1'b1;
    alloc_addr_i   = addr;
    alloc_len_i    = len;
    alloc_attr_i   = exp_tag[2:0];
    alloc_req_id_i = 16'hA000 | 16'(exp_tag);
    chk("alloc_rdy", alloc_ready_o, 1);
    chk("alloc_tag", alloc_tag_o, exp_tag);
    step();
    alloc_valid_i = 1'b0;
  endtask

  task automatic cpl(input logic [TAG_W-1:0] tag, input logic [LEN_W:0] dw);
    cpl_valid_i = 1'b1;
    cpl_tag_i   = tag;
    cpl_dw_i    = dw;
    step();
    cpl_valid_i = 1'b0;
  endtask

  task automatic lookup(input logic [TAG_W-1:0] tag);
    lk_valid_i = 1'b1;
    lk_tag_i   = tag;
    step();
    lk_valid_i = 1'b0;
  endtask

  task automatic chk_rsp(input logic hit, input logic [31:0] addr, input logic [LEN_W:0] rem,
                         input logic [2:0] attr, input logic [15:0] rid);
    chk("rsp_valid", rsp_valid_o, 1);
    chk("rsp_hit", rsp_hit_o, hit);
    chk("rsp_addr", rsp_addr_o, addr);
    chk("rsp_rem", rsp_rem_dw_o, rem);
    chk("rsp_attr", rsp_attr_o, attr);
    chk("rsp_req_id", rsp_req_id_o, rid);
  endtask

  task automatic drain();
    for (int i = 0; i < 2*TMO_CYC + 2*NUM_TAGS + 10 && outstanding_o != 0; i++) step();
    chk("drain", outstanding_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    alloc_valid_i = 0; alloc_req_id_i = 0; alloc_addr_i = 0; alloc_len_i = 0; alloc_attr_i = 0;
    lk_valid_i = 0; lk_tag_i = 0; rsp_ready_i = 1; cpl_valid_i = 0; cpl_tag_i = 0; cpl_dw_i = 0;
    repeat (3) step();
    chk("rst_outst", outstanding_o, 0);
    chk("rst_rdy", alloc_ready_o, 1);
    chk("rst_tag", alloc_tag_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_addr", rsp_addr_o, 0);
    chk("rst_tmo", tmo_valid_o, 0);
    chk("rst_err", err_ovr_o, 0);
    chk("rst_lk_rdy", lk_ready_o, 1);
    rst_n = 1'b1;
    step();

    // 1: three allocs, len 0 means 1024 DW
    alloc(32'h1000, 4, 0);
    alloc(32'h2000, 0, 1);
    alloc(32'h3000, 8, 2);
    chk("t1_outst", outstanding_o, 3);
    lookup(1);
    chk_rsp(1, 32'h2000, 1024, 1, 16'hA001);

    // 2: split completion on tag0
    cpl(0, 2);
    chk("t2_err_part", err_ovr_o, 0);
    lookup(0);
    chk_rsp(1, 32'h1008, 2, 0, 16'hA000);
    cpl(0, 2);
    chk("t2_err_final", err_ovr_o, 0);
    chk("t2_outst", outstanding_o, 2);
    chk("t2_tag", alloc_tag_o, 0);
    lookup(0);
    chk_rsp(0, 0, 0, 0, 0);
    drain();

    // 3: fill pool, then free tag 37
    for (int i = 0; i < NUM_TAGS; i++) alloc(32'h4000 + 32'(i * 64), 1, TAG_W'(i));
    chk("t3_full_rdy", alloc_ready_o, 0);
    chk("t3_full_outst", outstanding_o, NUM_TAGS);
    cpl(37, 1);
    chk("t3_outst", outstanding_o, NUM_TAGS - 1);
    chk("t3_rdy", alloc_ready_o, 1);
    chk("t3_tag", alloc_tag_o, 37);
    drain();

    // 4: timeout of an abandoned tag
    alloc(32'h5000, 4, 0);
    chk("t4_outst", outstanding_o, 1);
    n = 0;
    while (!tmo_valid_o && n <= TMO_CYC + NUM_TAGS) begin
      step();
      n++;
    end
    chk("t4_tmo_seen", tmo_valid_o, 1);
    chk("t4_tmo_tag", tmo_tag_o, 0);
    chk("t4_outst_drop", outstanding_o, 0);
    chk("t4_not_early", n >= TMO_CYC, 1);
    chk("t4_not_late", n <= TMO_CYC + NUM_TAGS - 1, 1);
    step();
    chk("t4_pulse_end", tmo_valid_o, 0);

    // 5: overrun and completion on a free tag
    alloc(32'h8000, 3, 0);
    cpl(0, 5);
    chk("t5_err", err_ovr_o, 1);
    chk("t5_outst", outstanding_o, 0);
    chk("t5_tag", alloc_tag_o, 0);
    step();
    chk("t5_err_pulse", err_ovr_o, 0);
    cpl(0, 1);
    chk("t5_err_free", err_ovr_o, 1);
    chk("t5_outst_free", outstanding_o, 0);

    // 6: stalled response, alloc+free same cycle, lookup sees pre-update context
    alloc(32'h100, 4, 0);
    alloc(32'h200, 2, 1);
    rsp_ready_i = 0;
    lookup(0);
    lk_valid_i = 1; lk_tag_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_hold_valid", rsp_valid_o, 1);
      chk("t6_hold_rem", rsp_rem_dw_o, 4);
      chk("t6_hold_addr", rsp_addr_o, 32'h100);
      chk("t6_lk_rdy", lk_ready_o, 0);
    end
    rsp_ready_i = 1;
    #1;
    chk("t6_lk_rdy_rel", lk_ready_o, 1);
    step();
    lk_valid_i = 0;
    chk_rsp(1, 32'h200, 2, 1, 16'hA001);
    step();
    chk("t6_rsp_drop", rsp_valid_o, 0);
    alloc_valid_i = 1; alloc_addr_i = 32'h300; alloc_len_i = 5; alloc_attr_i = 2; alloc_req_id_i = 16'hA002;
    chk("t6_sim_tag", alloc_tag_o, 2);
    cpl(1, 2);
    alloc_valid_i = 0;
    chk("t6_sim_outst", outstanding_o, 2);
    chk("t6_sim_next_tag", alloc_tag_o, 1);
    lk_valid_i = 1; lk_tag_i = 0;
    cpl(0, 1);
    lk_valid_i = 0;
    chk_rsp(1, 32'h100, 4, 0, 16'hA000);
    lookup(0);
    chk_rsp(1, 32'h104, 3, 0, 16'hA000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
